// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the multi-core work dispatcher: core state encoding,
// block padding constants, the 32-bit xor-fold and the default-width result record.
package dispatch_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StHold} core_state_e;

    localparam logic [7:0]  BlockPadHead = 8'h80;
    localparam logic [15:0] BlockPadLen  = 16'h0280;

    localparam int unsigned DefJobIdW = 4;
    localparam int unsigned DefNonceW = 32;

    typedef struct packed {
        logic [DefJobIdW-1:0] job_id;
        logic [DefNonceW-1:0] nonce;
    } result_t;

    // Low bit of the lower hash byte feeding fold byte k; its partner sits 128 bits higher.
    function automatic int unsigned fold_lo_bit(int unsigned k);
        return 128 + 8 * k;
    endfunction

    function automatic logic [31:0] xor_fold(logic [511:0] h);
        logic [31:0] f;
        f = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            f[31-8*k -: 8] = h[fold_lo_bit(k)+128 +: 8] ^ h[fold_lo_bit(k) +: 8];
        end
        return f;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO with an occupancy counter; the head entry is visible combinationally.
module result_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full    = count_q == (PtrW+1)'(Depth);
    assign empty   = count_q == '0;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/work_dispatcher.sv
// Interleaves one work unit across NUM_CORES hash cores, xor-fold checks each hash and queues hits.
// Define DISPATCH_STATS_EN to add saturating hash_count / hit_count / stall_cycles outputs.
module work_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned NONCE_W    = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned JOB_ID_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        new_work,
    input  logic [511:0]                midstate,
    input  logic [95:0]                 header,
    input  logic [NONCE_W-1:0]          nonce_start,
    input  logic [NONCE_W-1:0]          nonce_end,
    input  logic [31:0]                 target,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [512*NUM_CORES-1:0]    core_block,
    output logic [511:0]                core_midstate,
    input  logic [NUM_CORES-1:0]        core_ready,
    input  logic [512*NUM_CORES-1:0]    core_hash,
    output logic                        hashing,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [JOB_ID_W+NONCE_W-1:0] result_data
`ifdef DISPATCH_STATS_EN
    ,
    output logic [47:0]                 hash_count,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 stall_cycles
`endif
);
    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned ResW = JOB_ID_W + NONCE_W;
    localparam logic [NONCE_W:0] Stride = (NONCE_W+1)'(NUM_CORES);

    logic [511:0]         midstate_q;
    logic [95:0]          header_q;
    logic [NONCE_W-1:0]   start_q, span_q;
    logic [31:0]          target_q;
    logic [JOB_ID_W-1:0]  job_id_q;
    core_state_e          state_q  [NUM_CORES];
    logic [NONCE_W:0]     offset_q [NUM_CORES];

    logic [NONCE_W-1:0]   span_in;
    logic [NONCE_W-1:0]   nonce [NUM_CORES];
    logic [NUM_CORES-1:0] hit, last, in_run, in_hold;
    logic                 push_valid, push_en, fifo_full, fifo_empty, pop;
    logic [IdxW-1:0]      push_idx;
    logic [ResW-1:0]      push_data, fifo_head;

    assign span_in = nonce_end - nonce_start;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            nonce[i]   = start_q + offset_q[i][NONCE_W-1:0];
            hit[i]     = xor_fold(core_hash[i*512 +: 512]) <= target_q;
            last[i]    = (offset_q[i] + Stride) > {1'b0, span_q};
            in_run[i]  = state_q[i] == StRun;
            in_hold[i] = state_q[i] == StHold;
        end
    end

    // Lowest-index held core owns the single push slot.
    always_comb begin
        push_valid = 1'b0;
        push_idx   = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (in_hold[i]) begin
                push_valid = 1'b1;
                push_idx   = IdxW'(i);
            end
        end
    end

    assign result_valid  = !fifo_empty;
    assign pop           = result_valid && result_ready;
    assign push_en       = push_valid && !new_work && (!fifo_full || pop);
    assign push_data     = {job_id_q, nonce[push_idx]};
    assign result_data   = result_valid ? fifo_head : '0;
    assign hashing       = |(in_run | in_hold);
    assign core_midstate = midstate_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_block
        assign core_block[g*512 +: 512] =
            {header_q, 32'(nonce[g]), BlockPadHead, 360'd0, BlockPadLen};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            midstate_q <= '0;
            header_q   <= '0;
            start_q    <= '0;
            span_q     <= '0;
            target_q   <= '0;
            job_id_q   <= '0;
            core_start <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i]  <= StIdle;
                offset_q[i] <= '0;
            end
        end else begin
            core_start <= '0;
            if (new_work) begin
                midstate_q <= midstate;
                header_q   <= header;
                start_q    <= nonce_start;
                span_q     <= span_in;
                target_q   <= target;
                job_id_q   <= job_id_q + 1'b1;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if ((NONCE_W+1)'(i) <= {1'b0, span_in}) begin
                        state_q[i]    <= StRun;
                        offset_q[i]   <= (NONCE_W+1)'(i);
                        core_start[i] <= 1'b1;
                    end else begin
                        state_q[i]  <= StIdle;
                        offset_q[i] <= '0;
                    end
                end
            end else begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    unique case (state_q[i])
                        StRun: begin
                            if (core_ready[i]) begin
                                if (hit[i]) begin
                                    state_q[i] <= StHold;
                                end else if (last[i]) begin
                                    state_q[i] <= StIdle;
                                end else begin
                                    offset_q[i]   <= offset_q[i] + Stride;
                                    core_start[i] <= 1'b1;
                                end
                            end
                        end
                        StHold: begin
                            if (push_en && push_idx == IdxW'(i)) begin
                                if (last[i]) begin
                                    state_q[i] <= StIdle;
                                end else begin
                                    state_q[i]    <= StRun;
                                    offset_q[i]   <= offset_q[i] + Stride;
                                    core_start[i] <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    result_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (ResW)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_en),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef DISPATCH_STATS_EN
    logic [IdxW:0] ready_run;
    logic [48:0]   hash_sum;

    always_comb begin
        ready_run = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            ready_run = ready_run + (IdxW+1)'(core_ready[i] && in_run[i]);
        end
    end

    assign hash_sum = {1'b0, hash_count} + 49'(ready_run);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_count   <= '0;
            hit_count    <= '0;
            stall_cycles <= '0;
        end else begin
            hash_count <= hash_sum[48] ? '1 : hash_sum[47:0];
            if (push_en && hit_count != '1) hit_count <= hit_count + 1'b1;
            if ((|in_hold) && fifo_full && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_work_dispatcher.sv
// Randomised bench for work_dispatcher: behavioural core/consumer model, nonce-sequence and
// result-multiset reference, plus directed contention, backpressure, restart and no-hit cases.
module tb_work_dispatcher;
    import dispatch_pkg::*;

    localparam int unsigned NUM_CORES  = 4;
    localparam int unsigned NONCE_W    = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned JOB_ID_W   = 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        new_work = 1'b0;
    logic [511:0]                midstate = '0;
    logic [95:0]                 header = '0;
    logic [NONCE_W-1:0]          nonce_start = '0;
    logic [NONCE_W-1:0]          nonce_end = '0;
    logic [31:0]                 target = '0;
    logic [NUM_CORES-1:0]        core_start;
    logic [512*NUM_CORES-1:0]    core_block;
    logic [511:0]                core_midstate;
    logic [NUM_CORES-1:0]        core_ready = '0;
    logic [512*NUM_CORES-1:0]    core_hash = '0;
    logic                        hashing;
    logic                        result_valid;
    logic                        result_ready = 1'b0;
    logic [JOB_ID_W+NONCE_W-1:0] result_data;

    work_dispatcher #(
        .NUM_CORES  (NUM_CORES),
        .NONCE_W    (NONCE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .JOB_ID_W   (JOB_ID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_work      (new_work),
        .midstate      (midstate),
        .header        (header),
        .nonce_start   (nonce_start),
        .nonce_end     (nonce_end),
        .target        (target),
        .core_start    (core_start),
        .core_block    (core_block),
        .core_midstate (core_midstate),
        .core_ready    (core_ready),
        .core_hash     (core_hash),
        .hashing       (hashing),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model of the current job and of the external cores / consumer.
    int           jid;
    logic [31:0]  m_start, m_span, m_target;
    logic [95:0]  m_header;
    logic [511:0] m_mid;
    int           issues_total;
    int           issues_core [NUM_CORES];
    bit           pend [NUM_CORES];
    int           cnt [NUM_CORES];
    logic [31:0]  pnonce [NUM_CORES];
    int           dmin, dmax, rdy_pct, force_fold;
    bit           quiet;
    longint       cyc, first_ready_cyc, first_valid_cyc;
    logic [35:0]  exp_q[$];
    logic [35:0]  got_q[$];
    int           st_core[$];
    longint       st_cyc[$];
    int           s4_ord[5] = '{0, 1, 4, 2, 3};

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_cores();
        for (int i = 0; i < NUM_CORES; i++) begin
            pend[i] = 1'b0;
            cnt[i] = 0;
            issues_core[i] = 0;
        end
        issues_total = 0;
        first_ready_cyc = -1;
        first_valid_cyc = -1;
        st_core.delete();
        st_cyc.delete();
    endtask

    task automatic step();
        logic [511:0] h, blk;
        logic [31:0]  f, n, e;
        @(negedge clk);
        cyc++;
        new_work = 1'b0;
        check("midstate", core_midstate, m_mid);
        if (!result_valid) check("data_idle", result_data, 0);
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_start[i]) begin
                n = core_block[i*512+384 +: 32];
                e = m_start + 32'(i) + 32'(NUM_CORES) * 32'(issues_core[i]);
                check("issue_nonce", n, e);
                check("issue_in_span",
                      longint'(i) + longint'(NUM_CORES) * issues_core[i] <= longint'(m_span), 1);
                check("core_free", pend[i], 0);
                blk = {m_header, e, 8'h80, 360'd0, 16'h0280};
                check("block", core_block[i*512 +: 512], blk);
                issues_core[i]++;
                issues_total++;
                pend[i] = 1'b1;
                cnt[i] = $urandom_range(dmax, dmin);
                pnonce[i] = e;
                st_core.push_back(i);
                st_cyc.push_back(cyc);
            end
        end
        result_ready = ($urandom_range(99, 0) < rdy_pct);
        if (result_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (result_valid && result_ready) got_q.push_back(result_data);
        core_ready = '0;
        if (!quiet) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pend[i]) begin
                    if (cnt[i] == 0) begin
                        f = (force_fold >= 0) ? 32'(force_fold) : $urandom();
                        for (int j = 0; j < 16; j++) h[32*j +: 32] = $urandom();
                        for (int k = 0; k < 4; k++) h[256+8*k +: 8] = h[128+8*k +: 8] ^ f[31-8*k -: 8];
                        core_hash[i*512 +: 512] = h;
                        core_ready[i] = 1'b1;
                        pend[i] = 1'b0;
                        if (first_ready_cyc < 0) first_ready_cyc = cyc;
                        if (f <= m_target) exp_q.push_back({4'(jid), pnonce[i]});
                    end else begin
                        cnt[i]--;
                    end
                end
            end
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t);
        quiet = 1'b1;
        step();
        quiet = 1'b0;
        for (int j = 0; j < 16; j++) midstate[32*j +: 32] = $urandom();
        for (int j = 0; j < 3; j++) header[32*j +: 32] = $urandom();
        nonce_start = s;
        nonce_end = e;
        target = t;
        new_work = 1'b1;
        jid++;
        m_start = s;
        m_span = e - s;
        m_target = t;
        m_mid = midstate;
        m_header = header;
        clear_cores();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        new_work = 1'b0;
        core_ready = '0;
        result_ready = 1'b0;
        #1;
        check("rst_core_start", core_start, 0);
        check("rst_hashing", hashing, 0);
        check("rst_valid", result_valid, 0);
        check("rst_data", result_data, 0);
        check("rst_midstate", core_midstate, 0);
        jid = 0;
        m_start = '0;
        m_span = '0;
        m_target = '0;
        m_header = '0;
        m_mid = '0;
        exp_q.delete();
        got_q.delete();
        clear_cores();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((hashing || result_valid) && n < budget);
        check("drain_done", {hashing, result_valid}, 0);
    endtask

    task automatic compare_results(input string tag);
        logic [35:0] e;
        int idx;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            idx = -1;
            for (int j = 0; j < got_q.size(); j++) begin
                if (idx < 0 && got_q[j] == e) idx = j;
            end
            check({tag, "_found"}, idx >= 0, 1);
            if (idx >= 0) got_q.delete(idx);
        end
        check({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    initial begin
        result_t r;
        logic [31:0] s, span;
        cyc = 0;
        jid = 0;
        quiet = 1'b0;
        force_fold = -1;
        dmin = 0;
        dmax = 3;
        rdy_pct = 70;
        do_reset();

        // Full range 0..9, everything hits.
        start_job(32'd0, 32'd9, 32'hFFFF_FFFF);
        drain(500);
        check("s1_issues", issues_total, 10);
        check("s1_exp_count", exp_q.size(), 10);
        check("s1_hashing_done", hashing, 0);
        compare_results("s1");

        // Range wrapping through all-ones.
        start_job(32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF);
        drain(500);
        check("s2_issues", issues_total, 4);
        check("s2_core0_once", issues_core[0], 1);
        compare_results("s2");

        // All four cores ready together: serialized pushes and staggered restarts.
        do_reset();
        dmin = 2;
        dmax = 2;
        rdy_pct = 100;
        start_job(32'd0, 32'd7, 32'hFFFF_FFFF);
        drain(500);
        check("s3_issues", issues_total, 8);
        check("s3_latency", first_valid_cyc - first_ready_cyc, 2);
        for (int i = 0; i < NUM_CORES; i++) begin
            check("s3_restart_core", st_core[4+i], i);
            check("s3_restart_stagger", st_cyc[4+i] - st_cyc[4], i);
        end
        check("s3_got_count", got_q.size(), 8);
        for (int k = 0; k < 4; k++) check("s3_push_order", got_q[k][31:0], k);
        compare_results("s3");

        // Backpressure: FIFO fills, remaining hits stall, then all drain.
        do_reset();
        dmin = 1;
        dmax = 1;
        rdy_pct = 0;
        start_job(32'd0, 32'd4, 32'hFFFF_FFFF);
        repeat (20) step();
        check("s4_full_valid", result_valid, 1);
        check("s4_stalled_busy", hashing, 1);
        check("s4_issues", issues_total, 5);
        check("s4_nothing_popped", got_q.size(), 0);
        rdy_pct = 100;
        drain(200);
        check("s4_got_count", got_q.size(), 5);
        for (int k = 0; k < 5; k++) check("s4_order", got_q[k][31:0], s4_ord[k]);
        compare_results("s4");

        // Restart with two queued results from the previous job.
        do_reset();
        rdy_pct = 0;
        start_job(32'd0, 32'd99, 32'hFFFF_FFFF);
        repeat (15) step();
        check("s5_queued", result_valid, 1);
        start_job(32'd1000, 32'd1009, 32'hFFFF_FFFF);
        exp_q.delete();
        exp_q.push_back({4'd1, 32'd0});
        exp_q.push_back({4'd1, 32'd1});
        rdy_pct = 100;
        drain(300);
        check("s5_issues", issues_total, 10);
        r = got_q[0];
        check("s5_old_job0", r.job_id, 1);
        check("s5_old_nonce0", r.nonce, 0);
        r = got_q[1];
        check("s5_old_job1", r.job_id, 1);
        check("s5_old_nonce1", r.nonce, 1);
        compare_results("s5");

        // Single nonce, miss.
        do_reset();
        force_fold = 1;
        dmin = 2;
        dmax = 2;
        start_job(32'd5, 32'd5, 32'd0);
        for (int k = 0; k < 20 && first_ready_cyc < 0; k++) step();
        check("s6_ready_seen", first_ready_cyc >= 0, 1);
        check("s6_busy_at_ready", hashing, 1);
        step();
        check("s6_idle_after", hashing, 0);
        repeat (5) step();
        check("s6_valid", result_valid, 0);
        check("s6_issues", issues_total, 1);
        check("s6_core0", issues_core[0], 1);
        compare_results("s6");
        force_fold = -1;

        // Random jobs with random targets, latencies and consumer stalls.
        do_reset();
        dmin = 0;
        dmax = 4;
        for (int it = 0; it < 6; it++) begin
            s = $urandom();
            if (it % 2 == 1) s = 32'hFFFF_FFF0 + $urandom_range(15, 0);
            span = $urandom_range(40, 0);
            rdy_pct = $urandom_range(100, 20);
            start_job(s, s + span, $urandom());
            drain(2000);
            check("rnd_issues", issues_total, span + 1);
            compare_results("rnd");
        end

        // Reset mid-run, then job numbering restarts.
        rdy_pct = 50;
        start_job(32'd100, 32'd180, 32'hFFFF_FFFF);
        repeat (10) step();
        do_reset();
        rdy_pct = 80;
        start_job(32'd7, 32'd9, 32'hFFFF_FFFF);
        drain(500);
        check("post_rst_issues", issues_total, 3);
        compare_results("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
